// File: rtl/gate_truth_checker_pkg.sv
// gate_truth_checker_pkg: gate encodings, checker states and golden truth-table function
// Provides package gate_pkg:
//   gate_e          gate_sel encodings GATE_AND..GATE_XNOR (6,7 unused/invalid)
//   state_e         checker FSM states
//   gate_valid      1 when a gate_sel value names a real gate
//   gate_expected   golden y for (sel, a, b); 0 for invalid selections
package gate_pkg;
  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NAND = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_XOR  = 3'd4,
    GATE_XNOR = 3'd5
  } gate_e;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;
  function automatic logic gate_valid(input logic [2:0] sel);
    return sel <= 3'd5;
  endfunction
  function automatic logic gate_expected(input logic [2:0] sel, input logic a, input logic b);
    return sel == GATE_AND  ?  (a & b) :
           sel == GATE_OR   ?  (a | b) :
           sel == GATE_NAND ? ~(a & b) :
           sel == GATE_NOR  ? ~(a | b) :
           sel == GATE_XOR  ?  (a ^ b) :
           sel == GATE_XNOR ? ~(a ^ b) : 1'b0;
  endfunction
endpackage

// File: rtl/gate_truth_checker_if.sv
// gate_truth_checker_if: control, stimulus and result signals between a lab top and the checker
// Signals (named from the checker's side):
//   start_i      one-cycle sweep request
//   gate_sel_i   gate under test (0 AND .. 5 XNOR; 6,7 invalid)
//   y_i          output of the gate under test
//   a_o, b_o     registered stimulus to the gate inputs
//   busy_o       sweep in progress
//   done_o       one-cycle completion pulse
//   pass_o       all four vectors matched
//   fail_vec_o   bit i set = vector {a,b}=i mismatched
//   err_count_o  number of mismatching vectors, 0..4
// Modports: master = lab top / bench, slave = checker.
interface gate_truth_checker_if;
  logic       start_i;
  logic [2:0] gate_sel_i;
  logic       y_i;
  logic       a_o;
  logic       b_o;
  logic       busy_o;
  logic       done_o;
  logic       pass_o;
  logic [3:0] fail_vec_o;
  logic [2:0] err_count_o;
  modport master (
    output start_i, gate_sel_i, y_i,
    input  a_o, b_o, busy_o, done_o, pass_o, fail_vec_o, err_count_o
  );
  modport slave (
    input  start_i, gate_sel_i, y_i,
    output a_o, b_o, busy_o, done_o, pass_o, fail_vec_o, err_count_o
  );
endinterface

// File: rtl/gate_truth_checker_ref.sv
// gate_ref_model: combinational golden gate, sel/a/b -> expected y
// Ports:
//   sel_i     gate selection (gate_pkg encoding)
//   a_i, b_i  gate inputs
//   y_exp_o   expected gate output (0 for invalid selections)
module gate_ref_model
  import gate_pkg::*;
(
  input  logic [2:0] sel_i,
  input  logic       a_i,
  input  logic       b_i,
  output logic       y_exp_o
);
  assign y_exp_o = gate_expected(sel_i, a_i, b_i);
endmodule

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: drives all four a/b vectors into a 2-input gate and checks y against its truth table
// Ports:
//   clk   clock, all flops on posedge
//   rst   asynchronous active-high reset
//   bus   gate_truth_checker_if.slave (start/gate_sel/y in; a/b/busy/done/pass/fail_vec/err_count out)
// Parameter SETTLE_CYCLES (>= 1): clocks between driving a vector and sampling y.
module gate_truth_checker
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  gate_truth_checker_if.slave bus
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  state_e        state_q;
  logic [2:0]    sel_q;
  logic [1:0]    idx_q;
  logic [CW-1:0] cnt_q;
  logic          a_q, b_q, busy_q, done_q, pass_q;
  logic [3:0]    fail_q;
  logic [2:0]    err_q;
  logic          y_exp, miss;
  logic [3:0]    fail_d;
  logic [2:0]    err_d;
  logic [1:0]    idx_d;
  gate_ref_model u_ref (
    .sel_i   (sel_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .y_exp_o (y_exp)
  );
  // Anything other than an exact match (including X/Z on y) is a miss.
  always_comb begin
    miss = 1'b1;
    if (bus.y_i == y_exp) miss = 1'b0;
    fail_d = fail_q | (miss ? 4'b0001 << idx_q : 4'b0000);
    err_d  = err_q + {2'b00, miss};
    idx_d  = idx_q + 2'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 4'h0;
      err_q   <= 3'd0;
    end else begin
      case (state_q)
        IDLE: if (bus.start_i) begin
          sel_q      <= bus.gate_sel_i;
          idx_q      <= 2'd0;
          cnt_q      <= '0;
          {a_q, b_q} <= 2'b00;
          pass_q     <= 1'b0;
          busy_q     <= gate_valid(bus.gate_sel_i);
          fail_q     <= gate_valid(bus.gate_sel_i) ? 4'h0 : 4'hF;
          err_q      <= gate_valid(bus.gate_sel_i) ? 3'd0 : 3'd4;
          state_q    <= gate_valid(bus.gate_sel_i) ? SETTLE : DONE;
        end
        SETTLE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= SAMPLE;
        end
        SAMPLE: begin
          fail_q <= fail_d;
          err_q  <= err_d;
          if (idx_q == 2'd3) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= err_d == 3'd0;
          end else begin
            idx_q      <= idx_d;
            {a_q, b_q} <= idx_d;
            cnt_q      <= '0;
            state_q    <= SETTLE;
          end
        end
        // A sweep enters DONE with done already raised and leaves after one cycle;
        // an invalid selection enters with done low, so it raises done here and
        // stays one more cycle, which places its pulse in cycle 2.
        DONE: begin
          done_q <= ~done_q;
          if (done_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.a_o         = a_q;
  assign bus.b_o         = b_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.pass_o      = pass_q;
  assign bus.fail_vec_o  = fail_q;
  assign bus.err_count_o = err_q;
endmodule

// File: tb/tb_gate_truth_checker.sv
// tb_gate_truth_checker: randomized and directed checks of gate_truth_checker against a cycle-count model
module tb_gate_truth_checker;
  localparam int S = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] impl_tt = 4'h0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  gate_truth_checker_if if0 ();
  gate_truth_checker_if if1 ();
  gate_truth_checker #(.SETTLE_CYCLES(S)) dut (.clk(clk), .rst(rst), .bus(if0));
  gate_truth_checker #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  assign if0.y_i = impl_tt[{if0.a_o, if0.b_o}];
  assign if1.y_i = ~(if1.a_o | if1.b_o);
  function automatic logic [3:0] tt_of(input logic [2:0] sel);
    return sel == 3'd0 ? 4'b1000 : sel == 3'd1 ? 4'b1110 : sel == 3'd2 ? 4'b0111 :
           sel == 3'd3 ? 4'b0001 : sel == 3'd4 ? 4'b0110 : sel == 3'd5 ? 4'b1001 : 4'b0000;
  endfunction
  int m_t, m_l;
  logic m_valid;
  logic [3:0] m_fail;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t <= 0;
      m_l <= 0;
      m_valid <= 1'b0;
      m_fail <= 4'h0;
    end else if (if0.start_i && (m_t == 0 || m_t > m_l)) begin
      m_t <= 1;
      m_valid <= if0.gate_sel_i <= 3'd5;
      m_l <= (if0.gate_sel_i <= 3'd5) ? 4 * (S + 1) + 1 : 2;
      m_fail <= (if0.gate_sel_i <= 3'd5) ? (tt_of(if0.gate_sel_i) ^ impl_tt) : 4'hF;
    end else if (m_t != 0 && m_t <= m_l) begin
      m_t <= m_t + 1;
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0d)", name, act, req, m_t);
    end
  endtask
  task automatic compare();
    logic [1:0] e_ab;
    logic e_busy, e_done, e_pass;
    logic [3:0] e_fail;
    e_ab = 2'd0;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_pass = 1'b0;
    e_fail = 4'h0;
    if (m_t != 0 && !m_valid) begin
      e_done = m_t == 2;
      e_fail = 4'hF;
    end else if (m_t != 0) begin
      e_ab = m_t > 4 * (S + 1) ? 2'd3 : 2'((m_t - 1) / (S + 1));
      e_busy = m_t <= 4 * (S + 1);
      e_done = m_t == m_l;
      for (int k = 0; k < 4; k++) if ((k + 1) * (S + 1) + 1 <= m_t) e_fail[k] = m_fail[k];
      e_pass = m_t >= m_l && m_fail == 4'h0;
    end
    check("ab", {if0.a_o, if0.b_o}, e_ab);
    check("busy", if0.busy_o, e_busy);
    check("done", if0.done_o, e_done);
    check("pass", if0.pass_o, e_pass);
    check("fail_vec", if0.fail_vec_o, e_fail);
    check("err_count", if0.err_count_o, $countones(e_fail));
  endtask
  task automatic tick();
    @(negedge clk);
    compare();
  endtask
  task automatic pulse(input logic [2:0] sel);
    if0.gate_sel_i = sel;
    if0.start_i = 1'b1;
    tick();
    if0.start_i = 1'b0;
  endtask
  task automatic run_to_done(output int n);
    n = 1;
    while (!if0.done_o && n < 40) begin
      tick();
      n++;
    end
  endtask
  initial begin
    int n, dones, first;
    if0.start_i = 1'b0;
    if0.gate_sel_i = 3'd0;
    if1.start_i = 1'b0;
    if1.gate_sel_i = 3'd3;
    repeat (2) @(negedge clk);
    check("rst_busy", if0.busy_o, 1'b0);
    check("rst_ab", {if0.a_o, if0.b_o}, 2'b00);
    check("rst_fail", if0.fail_vec_o, 4'h0);
    rst = 1'b0;
    tick();
    impl_tt = 4'b0001;
    pulse(3'd3);
    run_to_done(n);
    check("nor_latency", n, 13);
    check("nor_pass", if0.pass_o, 1'b1);
    check("nor_fail", if0.fail_vec_o, 4'b0000);
    check("nor_err", if0.err_count_o, 3'd0);
    check("nor_ab", {if0.a_o, if0.b_o}, 2'b11);
    repeat (2) tick();
    impl_tt = 4'b1110;
    pulse(3'd3);
    run_to_done(n);
    check("or_as_nor_fail", if0.fail_vec_o, 4'b1111);
    check("or_as_nor_err", if0.err_count_o, 3'd4);
    check("or_as_nor_pass", if0.pass_o, 1'b0);
    repeat (2) tick();
    impl_tt = 4'b0000;
    pulse(3'd4);
    run_to_done(n);
    check("xor_sa0_fail", if0.fail_vec_o, 4'b0110);
    check("xor_sa0_err", if0.err_count_o, 3'd2);
    check("xor_sa0_pass", if0.pass_o, 1'b0);
    repeat (2) tick();
    pulse(3'd7);
    run_to_done(n);
    check("inv_latency", n, 2);
    check("inv_fail", if0.fail_vec_o, 4'hF);
    check("inv_err", if0.err_count_o, 3'd4);
    check("inv_ab", {if0.a_o, if0.b_o}, 2'b00);
    repeat (2) tick();
    impl_tt = 4'b0001;
    pulse(3'd3);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    check("arst_busy", if0.busy_o, 1'b0);
    check("arst_ab", {if0.a_o, if0.b_o}, 2'b00);
    check("arst_fail", if0.fail_vec_o, 4'h0);
    tick();
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      tick();
      dones += int'(if0.done_o);
    end
    check("arst_no_done", dones, 0);
    pulse(3'd3);
    run_to_done(n);
    check("arst_restart_latency", n, 13);
    check("arst_restart_pass", if0.pass_o, 1'b1);
    repeat (2) tick();
    pulse(3'd3);
    if0.gate_sel_i = 3'd4;
    tick();
    if0.start_i = 1'b1;
    tick();
    if0.start_i = 1'b0;
    repeat (4) tick();
    if0.start_i = 1'b1;
    tick();
    if0.start_i = 1'b0;
    dones = 0;
    first = 0;
    for (int t = 9; t <= 20; t++) begin
      tick();
      if (if0.done_o) begin
        dones++;
        if (first == 0) first = t;
      end
    end
    check("repulse_done_count", dones, 1);
    check("repulse_latency", first, 13);
    check("repulse_pass", if0.pass_o, 1'b1);
    if1.start_i = 1'b1;
    tick();
    if1.start_i = 1'b0;
    n = 1;
    while (!if1.done_o && n < 40) begin
      tick();
      n++;
    end
    check("s1_latency", n, 9);
    check("s1_pass", if1.pass_o, 1'b1);
    check("s1_fail", if1.fail_vec_o, 4'h0);
    repeat (30) begin
      impl_tt = 4'($urandom);
      pulse(3'($urandom_range(0, 7)));
      repeat (20) begin
        if ($urandom_range(0, 5) == 0) begin
          if0.gate_sel_i = 3'($urandom_range(0, 7));
          if0.start_i = 1'b1;
        end
        if ($urandom_range(0, 24) == 0) rst = 1'b1;
        tick();
        if0.start_i = 1'b0;
        rst = 1'b0;
      end
      n = 0;
      while (!(m_t == 0 || m_t > m_l) && n < 40) begin
        tick();
        n++;
      end
      check("rand_idle_timeout", n < 40, 1'b1);
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
